bsg_manycore_vcache_wh_to_mem: RTL and testbench
================================================

// Module: bsg_manycore_vcache_wh_to_mem
// PURPOSE
//  Memory-side endpoint of the 1D vcache DMA wormhole ruche network: sits at the E/W end of a vcache row.
//  Consumes cache-DMA wormhole packets, issues per-beat memory requests, returns read fills as wormhole packets.
//  One packet in flight; read header is sent before the first memory read is issued.
// PARAMETERS
//  wh_flit_width_p            "inv"  flit width; must equal vcache_dma_data_width_p and be >= vcache_addr_width_p
//  wh_cord_width_p            "inv"  wormhole x-cord width
//  wh_len_width_p             "inv"  wormhole length field width
//  wh_cid_width_p             "inv"  concentrator id width
//  vcache_addr_width_p        "inv"  byte address width
//  vcache_data_width_p        "inv"  cache word width
//  vcache_block_size_in_words_p "inv" words per cache block
//  vcache_dma_data_width_p    "inv"  DMA beat width; N = block_words*data_width/dma_width beats per block
// PORTS
//  clk_i          in   1      clock
//  reset_n_i      in   1      reset, asynchronous, active-low
//  wh_link_sif_i  in   bsg_ready_and_link_sif_width(wh_flit_width_p)  {v, data, ready_and_rev} from network
//  wh_link_sif_o  out  same   {v, data, ready_and_rev} to network
//  mem_v_o        out  1      memory request valid
//  mem_w_o        out  1      1=write, 0=read
//  mem_addr_o     out  vcache_addr_width_p      beat byte address
//  mem_data_o     out  vcache_dma_data_width_p  write beat data
//  mem_ready_i    in   1      request accepted when mem_v_o & mem_ready_i
//  mem_rdata_v_i  in   1      read data valid (in request order)
//  mem_rdata_i    in   vcache_dma_data_width_p  read data
//  mem_rdata_ready_o out 1    read data accepted when v & ready
// BEHAVIOUR
//  Header flit (LSB first): dest_cord[cord], len[len], src_cord[cord], cid[cid], write_not_read[1]; upper bits 0.
//  Flit 1: addr in [vcache_addr_width_p-1:0]. Write: len=N+1, N data flits follow. Read: len=1.
//  Reset (reset_n_i low, async): state=IDLE, counters=0, mem_v_o=0, mem_rdata_ready_o=0, link out v=0,
//   link out ready_and_rev=0; any partial packet discarded, no response generated.
//  All handshakes valid/ready; no output valid depends combinationally on its own ready.
//  States:
//   IDLE   : in ready=1; on header accept latch src_cord,cid,wnr -> ADDR.
//   ADDR   : in ready=1; on accept latch base addr, beat cnt=0 -> WR (wnr=1) else RHDR.
//   WR     : mem_v_o=in v, mem_w_o=1, mem_data_o=in data, in ready=mem_ready_i (pass-through, 0 latency);
//            cnt++ per accepted beat; after beat N-1 -> IDLE.
//   RHDR   : in ready=0; out v=1, out data = header{dest=src_cord, len=N, src_cord=0, cid, wnr=0};
//            on out ready -> RD with req cnt=0, rsp cnt=0.
//   RD     : mem_v_o=(req cnt<N), mem_w_o=0; req cnt++ on mem accept.
//            out v=mem_rdata_v_i, out data=mem_rdata_i, mem_rdata_ready_o=out ready (pass-through);
//            rsp cnt++ per forwarded beat; after beat N-1 -> IDLE. Request and response overlap freely.
//  mem_addr_o = base + cnt*(vcache_dma_data_width_p/8), wraps mod 2^vcache_addr_width_p.
//  Counters are clog2(N+1) bits; N=1 legal (single-beat WR/RD).
//  In WR/RD the input link accepts no new packet (in ready=0 in RD; in WR only data flits).
//  Simultaneous last-beat and state exit: next header accepted earliest the cycle after returning to IDLE.
//  mem_rdata_v_i outside RD is ignored (ready=0); simulation assertion flags it and write len != N+1.
// TESTING (flit=32, cord=8, len=4, cid=2, addr=32, 8 words x32b, dma=32 -> N=8)
//  Write pkt src=3,cid=2,addr=0x1000, data 0..7 -> 8 mem writes addr 0x1000..0x101C data 0..7, then IDLE.
//  Read pkt src=5,cid=1,addr=0x2000, mem returns 0xA0..0xA7 -> out hdr dest=5,len=8,cid=1 then 8 data flits in order.
//  Read with out ready toggled 50% and mem_ready_i random -> no lost/duplicated beats; mem reads stop at 8.
//  addr=0xFFFFFFF0 write -> beats wrap to 0x0..0xC after 0xFFFFFFFC.
//  reset_n_i low mid-write beat 3 -> outputs 0 immediately; next packet after release processed normally.
//  Back-to-back write then read headers queued on input -> read header accepted only after write beat 7.

Source files
------------

// File: rtl/bsg_manycore_vcache_wh_to_mem.sv
// rtl/bsg_manycore_vcache_wh_to_mem.sv - memory-side endpoint of the vcache DMA wormhole network
//
// Purpose: accepts cache-DMA wormhole packets (header, address, optional write
// data), turns them into per-beat memory requests, and returns read fills as a
// wormhole packet (header first, then N data flits). One packet in flight.
//
// Ports:
//   clk_i, reset_n_i          clock, asynchronous active-low reset
//   wh_link_sif_i             {v, data, ready_and_rev} from the network
//   wh_link_sif_o             {v, data, ready_and_rev} to the network
//   mem_v_o/mem_w_o           memory request valid / write-not-read
//   mem_addr_o/mem_data_o     beat byte address / write beat data
//   mem_ready_i               memory request accepted
//   mem_rdata_v_i/mem_rdata_i read data valid / data (in request order)
//   mem_rdata_ready_o         read data accepted
module bsg_manycore_vcache_wh_to_mem #(
    parameter int wh_flit_width_p              = 32,
    parameter int wh_cord_width_p              = 8,
    parameter int wh_len_width_p               = 4,
    parameter int wh_cid_width_p               = 2,
    parameter int vcache_addr_width_p          = 32,
    parameter int vcache_data_width_p          = 32,
    parameter int vcache_block_size_in_words_p = 8,
    parameter int vcache_dma_data_width_p      = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [wh_flit_width_p+1:0]         wh_link_sif_i,
    output logic [wh_flit_width_p+1:0]         wh_link_sif_o,
    output logic                               mem_v_o,
    output logic                               mem_w_o,
    output logic [vcache_addr_width_p-1:0]     mem_addr_o,
    output logic [vcache_dma_data_width_p-1:0] mem_data_o,
    input  logic                               mem_ready_i,
    input  logic                               mem_rdata_v_i,
    input  logic [vcache_dma_data_width_p-1:0] mem_rdata_i,
    output logic                               mem_rdata_ready_o
);

    localparam int N       = vcache_block_size_in_words_p * vcache_data_width_p / vcache_dma_data_width_p;
    localparam int CW      = $clog2(N + 1);
    localparam int BYTES   = vcache_dma_data_width_p / 8;
    localparam int C       = wh_cord_width_p;
    localparam int L       = wh_len_width_p;
    localparam int I       = wh_cid_width_p;
    localparam int A       = vcache_addr_width_p;
    localparam int F       = wh_flit_width_p;
    localparam int LEN_LSB = C;
    localparam int SRC_LSB = C + L;
    localparam int CID_LSB = 2 * C + L;
    localparam int WNR_BIT = 2 * C + L + I;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WR, S_RHDR, S_RD} state_e;

    state_e        r_state, w_next;
    logic [C-1:0]  r_src;
    logic [I-1:0]  r_cid;
    logic          r_wnr;
    logic [A-1:0]  r_base;
    logic [CW-1:0] r_req_cnt;
    logic [CW-1:0] r_rsp_cnt;

    logic          w_in_v, w_in_ready, w_out_v, w_out_ready;
    logic [F-1:0]  w_in_data, w_out_data;
    logic          w_unused;

    assign w_in_v      = wh_link_sif_i[F+1];
    assign w_in_data   = wh_link_sif_i[F:1];
    assign w_out_ready = wh_link_sif_i[0];
    // Header routing fields and high address bits are not needed here.
    assign w_unused    = ^w_in_data;

    // State is forced to IDLE while reset is held, so only the IDLE input
    // ready has to be masked to keep the link quiet during reset.
    assign wh_link_sif_o = {w_out_v, w_out_data, w_in_ready & reset_n_i};
    assign mem_addr_o    = r_base + A'(r_req_cnt) * A'(BYTES);

    always_comb begin
        w_next            = r_state;
        w_in_ready        = 1'b0;
        w_out_v           = 1'b0;
        w_out_data        = '0;
        mem_v_o           = 1'b0;
        mem_w_o           = 1'b0;
        mem_data_o        = '0;
        mem_rdata_ready_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (w_in_v) w_next = S_ADDR;
            end
            S_ADDR: begin
                w_in_ready = 1'b1;
                if (w_in_v) w_next = r_wnr ? S_WR : S_RHDR;
            end
            S_WR: begin
                // Write beats stream straight through to memory.
                mem_v_o    = w_in_v;
                mem_w_o    = 1'b1;
                mem_data_o = w_in_data[vcache_dma_data_width_p-1:0];
                w_in_ready = mem_ready_i;
                if (w_in_v && mem_ready_i && r_req_cnt == CW'(N - 1)) w_next = S_IDLE;
            end
            S_RHDR: begin
                w_out_v                      = 1'b1;
                w_out_data[C-1:0]            = r_src;
                w_out_data[LEN_LSB +: L]     = L'(N);
                w_out_data[CID_LSB +: I]     = r_cid;
                if (w_out_ready) w_next = S_RD;
            end
            S_RD: begin
                // Requests and fill forwarding proceed independently.
                mem_v_o           = (r_req_cnt < CW'(N));
                w_out_v           = mem_rdata_v_i;
                w_out_data        = F'(mem_rdata_i);
                mem_rdata_ready_o = w_out_ready;
                if (mem_rdata_v_i && w_out_ready && r_rsp_cnt == CW'(N - 1)) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state   <= S_IDLE;
            r_src     <= '0;
            r_cid     <= '0;
            r_wnr     <= 1'b0;
            r_base    <= '0;
            r_req_cnt <= '0;
            r_rsp_cnt <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_in_v) begin
                    r_src <= w_in_data[SRC_LSB +: C];
                    r_cid <= w_in_data[CID_LSB +: I];
                    r_wnr <= w_in_data[WNR_BIT];
                end
                S_ADDR: if (w_in_v) begin
                    r_base    <= w_in_data[A-1:0];
                    r_req_cnt <= '0;
                end
                S_WR: if (w_in_v && mem_ready_i) r_req_cnt <= r_req_cnt + 1'b1;
                S_RHDR: if (w_out_ready) begin
                    r_req_cnt <= '0;
                    r_rsp_cnt <= '0;
                end
                S_RD: begin
                    if (mem_v_o && mem_ready_i) r_req_cnt <= r_req_cnt + 1'b1;
                    if (mem_rdata_v_i && w_out_ready) r_rsp_cnt <= r_rsp_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    a_rdata_outside_rd: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(mem_rdata_v_i && r_state != S_RD))
        else $error("mem_rdata_v_i asserted outside read phase");

    a_write_len: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (r_state == S_IDLE && w_in_v && w_in_data[WNR_BIT]) |-> (w_in_data[LEN_LSB +: L] == L'(N + 1)))
        else $error("write packet length is not N+1");

endmodule

// File: tb/tb_bsg_manycore_vcache_wh_to_mem.sv
// tb/tb_bsg_manycore_vcache_wh_to_mem.sv - randomized self-checking bench for bsg_manycore_vcache_wh_to_mem
module tb_bsg_manycore_vcache_wh_to_mem;

    localparam int NB = 8;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic [33:0] wh_link_sif_i;
    logic [33:0] wh_link_sif_o;
    logic        mem_v_o, mem_w_o, mem_ready_i, mem_rdata_v_i, mem_rdata_ready_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_rdata_i;

    bsg_manycore_vcache_wh_to_mem dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .wh_link_sif_i(wh_link_sif_i), .wh_link_sif_o(wh_link_sif_o),
        .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_v_i(mem_rdata_v_i), .mem_rdata_i(mem_rdata_i),
        .mem_rdata_ready_o(mem_rdata_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int rd_hdr_cyc = 0;
    int n_rd_req = 0;
    int exp_rd_req = 0;

    logic [31:0] in_q[$];
    int          in_tag[$];      // 0 = body flit, 1 = write header, 2 = read header
    logic [31:0] exp_wa[$], exp_wd[$], obs_wa[$], obs_wd[$];
    logic [31:0] exp_out[$], obs_out[$];
    logic [31:0] rd_pend[$];
    logic [31:0] mem_arr [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] hdr(input int dest, input int len, input int src, input int cid, input int wnr);
        return 32'(dest & 8'hFF) | (32'(len & 4'hF) << 8) | (32'(src & 8'hFF) << 12)
             | (32'(cid & 2'h3) << 20) | (32'(wnr & 1) << 22);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return a ^ 32'hDEAD_0000;
    endfunction

    task automatic send_write(input int src, input int cid, input logic [31:0] addr, input logic [31:0] d[NB]);
        in_q.push_back(hdr(0, NB + 1, src, cid, 1)); in_tag.push_back(1);
        in_q.push_back(addr);                        in_tag.push_back(0);
        for (int i = 0; i < NB; i++) begin
            in_q.push_back(d[i]); in_tag.push_back(0);
            exp_wa.push_back(addr + 32'(4 * i));
            exp_wd.push_back(d[i]);
        end
    endtask

    task automatic send_read(input int src, input int cid, input logic [31:0] addr, input logic [31:0] d[NB]);
        in_q.push_back(hdr(0, 1, src, cid, 0)); in_tag.push_back(2);
        in_q.push_back(addr);                   in_tag.push_back(0);
        exp_out.push_back(hdr(src, NB, 0, cid, 0));
        for (int i = 0; i < NB; i++) begin
            mem_arr[addr + 32'(4 * i)] = d[i];
            exp_out.push_back(d[i]);
        end
        exp_rd_req += NB;
    endtask

    // One clock: drive at the falling edge, then record which handshakes the
    // next rising edge will complete.
    task automatic step();
        logic iv, ordy;
        @(negedge clk_i);
        cyc++;
        iv            = (in_q.size() > 0) && ($urandom_range(0, 4) != 0);
        ordy          = $urandom_range(0, 1) == 1;
        mem_ready_i   = $urandom_range(0, 1) == 1;
        mem_rdata_v_i = (rd_pend.size() > 0) && ($urandom_range(0, 3) != 0);
        mem_rdata_i   = mem_rdata_v_i ? mem_rd(rd_pend[0]) : 32'h0;
        wh_link_sif_i = {iv, (in_q.size() > 0) ? in_q[0] : 32'h0, ordy};
        #1;
        if (iv && wh_link_sif_o[0]) begin
            if (in_tag[0] == 2) rd_hdr_cyc = cyc;
            void'(in_q.pop_front());
            void'(in_tag.pop_front());
        end
        if (mem_rdata_v_i && mem_rdata_ready_o) void'(rd_pend.pop_front());
        if (mem_v_o && mem_ready_i) begin
            if (mem_w_o) begin
                obs_wa.push_back(mem_addr_o);
                obs_wd.push_back(mem_data_o);
                last_wr_cyc = cyc;
            end else begin
                rd_pend.push_back(mem_addr_o);
                n_rd_req++;
            end
        end
        if (wh_link_sif_o[33] && ordy) obs_out.push_back(wh_link_sif_o[32:1]);
    endtask

    task automatic run_and_compare(input string tag);
        int n = 0;
        while (!(in_q.size() == 0 && rd_pend.size() == 0 && obs_out.size() >= exp_out.size()
                 && obs_wa.size() >= exp_wa.size()) && n < 3000) begin
            step();
            n++;
        end
        for (int i = 0; i < 6; i++) step();  // catch extra/duplicated beats
        check({tag, "_done"}, 64'(n < 3000), 64'd1);
        check({tag, "_nwr"}, 64'(obs_wa.size()), 64'(exp_wa.size()));
        for (int i = 0; i < exp_wa.size() && i < obs_wa.size(); i++) begin
            check({tag, "_waddr"}, 64'(obs_wa[i]), 64'(exp_wa[i]));
            check({tag, "_wdata"}, 64'(obs_wd[i]), 64'(exp_wd[i]));
        end
        check({tag, "_nout"}, 64'(obs_out.size()), 64'(exp_out.size()));
        for (int i = 0; i < exp_out.size() && i < obs_out.size(); i++)
            check({tag, "_out"}, 64'(obs_out[i]), 64'(exp_out[i]));
        check({tag, "_nrdreq"}, 64'(n_rd_req), 64'(exp_rd_req));
        exp_wa.delete(); exp_wd.delete(); obs_wa.delete(); obs_wd.delete();
        exp_out.delete(); obs_out.delete(); n_rd_req = 0; exp_rd_req = 0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_memv"}, 64'(mem_v_o), 64'd0);
        check({tag, "_outv"}, 64'(wh_link_sif_o[33]), 64'd0);
        check({tag, "_inrdy"}, 64'(wh_link_sif_o[0]), 64'd0);
        check({tag, "_rdrdy"}, 64'(mem_rdata_ready_o), 64'd0);
    endtask

    initial begin
        logic [31:0] d[NB];
        int n;
        reset_n_i     = 1'b0;
        wh_link_sif_i = '0;
        mem_ready_i   = 1'b0;
        mem_rdata_v_i = 1'b0;
        mem_rdata_i   = '0;
        repeat (3) @(negedge clk_i);
        check_quiet("reset");
        reset_n_i = 1'b1;
        #1;
        check("idle_inrdy", 64'(wh_link_sif_o[0]), 64'd1);

        for (int i = 0; i < NB; i++) d[i] = 32'(i);
        send_write(3, 2, 32'h1000, d);
        run_and_compare("wr_basic");

        for (int i = 0; i < NB; i++) d[i] = 32'hA0 + 32'(i);
        send_read(5, 1, 32'h2000, d);
        run_and_compare("rd_basic");

        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_write(7, 3, 32'hFFFF_FFF0, d);
        run_and_compare("wr_wrap");

        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_read(9, 0, 32'hFFFF_FFF8, d);
        run_and_compare("rd_wrap");

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NB; i++) d[i] = $urandom;
            if ($urandom_range(0, 1) == 1) send_write($urandom_range(0, 255), $urandom_range(0, 3), $urandom, d);
            else                           send_read($urandom_range(0, 255), $urandom_range(0, 3), $urandom & 32'hFFFF_FFFC, d);
        end
        run_and_compare("random");

        // Back-to-back write then read: read header must wait for the last write beat.
        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_write(4, 1, 32'h3000, d);
        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_read(6, 2, 32'h4000, d);
        run_and_compare("b2b");
        check("b2b_order", 64'(rd_hdr_cyc > last_wr_cyc), 64'd1);

        // Reset in the middle of a write burst.
        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_write(2, 1, 32'h5000, d);
        n = 0;
        while (obs_wa.size() < 3 && n < 500) begin step(); n++; end
        check("rst_mid_reached", 64'(obs_wa.size()), 64'd3);
        @(negedge clk_i);
        reset_n_i = 1'b0;
        #1;
        check_quiet("rst_mid");
        in_q.delete(); in_tag.delete(); rd_pend.delete();
        exp_wa.delete(); exp_wd.delete(); obs_wa.delete(); obs_wd.delete();
        exp_out.delete(); obs_out.delete(); n_rd_req = 0; exp_rd_req = 0;
        wh_link_sif_i = '0;
        repeat (2) @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_write(8, 0, 32'h6000, d);
        for (int i = 0; i < NB; i++) d[i] = $urandom;
        send_read(1, 3, 32'h7000, d);
        run_and_compare("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
